// File: rtl/gfx_bitmap_display.sv
// gfx_bitmap_display: programmable raster timing generator with framebuffer fetch.
// Scans a bitmap of FB_WIDTH x FB_HEIGHT source pixels (1/2/4/8 bpp) from a
// synchronous byte RAM and applies integer X/Y replication. Active pixels that
// fall outside the bitmap window show BORDER_RGB.
// The colour, de, hsync and vsync outputs all lag the raster counters by 3 clk.
// Optional macro GFX_PALETTE_EN adds a 16-entry x 24-bit palette for BPP <= 4.
//
// Pipeline:
//   stage 0 : raster counters; the byte address is computed combinationally
//   stage 1 : dispAddr is registered and the RAM samples it
//   stage 2 : dispData is valid; the pixel is extracted and its colour mapped
//   stage 3 : registered video outputs
module gfx_bitmap_display #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter bit          SYNC_POL   = 1'b1,
    parameter int          FB_WIDTH   = 256,
    parameter int          FB_HEIGHT  = 256,
    parameter int          BPP        = 1,
    parameter int          SCALE_X    = 1,
    parameter int          SCALE_Y    = 1,
    parameter int          ADDR_W     = 13,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    output logic [ADDR_W-1:0] dispAddr,
    input  logic [7:0]        dispData,
    input  logic              pal_we,
    input  logic [3:0]        pal_addr,
    input  logic [23:0]       pal_data,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int PPB      = 8 / BPP;
    localparam int PPB_SH   = $clog2(PPB);
    localparam int SX_SH    = $clog2(SCALE_X);
    localparam int SY_SH    = $clog2(SCALE_Y);
    localparam int BPL      = FB_WIDTH * BPP / 8;
    localparam int WIN_W    = FB_WIDTH * SCALE_X;
    localparam int WIN_H    = FB_HEIGHT * SCALE_Y;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [7:0]    PIX_MASK = 8'((1 << BPP) - 1);

    // Fixed index-to-colour mapping; also the reset image of the palette.
    function automatic logic [23:0] map_colour(input logic [7:0] idx);
        logic [7:0] g;
        if (BPP == 8) begin
            return {idx[7:5], idx[7:5], idx[7:6],
                    idx[4:2], idx[4:2], idx[4:3],
                    {4{idx[1:0]}}};
        end
        if (BPP == 1)      g = {8{idx[0]}};
        else if (BPP == 2) g = {4{idx[1:0]}};
        else               g = {2{idx[3:0]}};
        return {g, g, g};
    endfunction

    logic [HW-1:0]     hcount;
    logic [VW-1:0]     vcount;
    logic              started;
    logic [ADDR_W-1:0] base;

    // Raster counters. The first clk after reset holds (0,0) and raises frame_start.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            started     <= 1'b0;
            frame_start <= 1'b0;
        end else if (!started) begin
            started     <= 1'b1;
            frame_start <= 1'b1;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            if (vcount == V_LAST) begin
                vcount      <= '0;
                frame_start <= 1'b1;
            end else begin
                vcount      <= vcount + VW'(1);
                frame_start <= 1'b0;
            end
        end else begin
            hcount      <= hcount + HW'(1);
            frame_start <= 1'b0;
        end
    end

    logic [31:0]       hx, vy, src_x, src_y, byte_x;
    logic              active0, win0, hs0, vs0;
    logic [2:0]        pix0;
    logic [ADDR_W-1:0] base_eff, addr0;

    assign hx      = 32'(hcount);
    assign vy      = 32'(vcount);
    assign active0 = started && (hx < 32'(H_ACTIVE)) && (vy < 32'(V_ACTIVE));
    assign win0    = (hx < 32'(WIN_W)) && (vy < 32'(WIN_H));
    assign hs0     = started && (hx >= 32'(HS_START)) && (hx < 32'(HS_END));
    assign vs0     = started && (vy >= 32'(VS_START)) && (vy < 32'(VS_END));
    assign src_x   = hx >> SX_SH;
    assign src_y   = vy >> SY_SH;
    assign byte_x  = src_x >> PPB_SH;
    assign pix0    = 3'(src_x & 32'(PPB - 1));
    // The frame that starts now already uses the freshly presented base.
    assign base_eff = frame_start ? fb_base : base;
    assign addr0    = base_eff + ADDR_W'(src_y * 32'(BPL) + byte_x);

    // Base latch and fetch address; the address is held outside the window.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            base     <= '0;
            dispAddr <= '0;
        end else begin
            if (frame_start)
                base <= fb_base;
            if (active0 && win0)
                dispAddr <= addr0;
        end
    end

    logic       act1, win1, hs1, vs1, act2, win2, hs2, vs2;
    logic [2:0] pix1, pix2;

    // Delay line that keeps timing flags in step with the RAM read data.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            act1 <= 1'b0;
            win1 <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            pix1 <= '0;
            act2 <= 1'b0;
            win2 <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
            pix2 <= '0;
        end else begin
            act1 <= active0;
            win1 <= win0;
            hs1  <= hs0;
            vs1  <= vs0;
            pix1 <= pix0;
            act2 <= act1;
            win2 <= win1;
            hs2  <= hs1;
            vs2  <= vs1;
            pix2 <= pix1;
        end
    end

    logic [7:0]  idx2;
    logic [23:0] pix_rgb;

    assign idx2 = 8'(dispData >> (32'(pix2) * 32'(BPP))) & PIX_MASK;

`ifdef GFX_PALETTE_EN
    logic [23:0] pal [16];

    // Palette register file; a write is seen by the lookup on the next clk.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                pal[i] <= map_colour(8'(i));
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    assign pix_rgb = (BPP <= 4) ? pal[idx2[3:0]] : map_colour(idx2);
`else
    logic pal_unused;

    assign pal_unused = ^{pal_we, pal_addr, pal_data};
    assign pix_rgb    = map_colour(idx2);
`endif

    // Registered video outputs; blanked colour outside the active area.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            de    <= 1'b0;
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            de    <= act2;
            hsync <= hs2 ? SYNC_POL : ~SYNC_POL;
            vsync <= vs2 ? SYNC_POL : ~SYNC_POL;
            if (!act2)
                {red, green, blue} <= 24'h000000;
            else if (win2)
                {red, green, blue} <= pix_rgb;
            else
                {red, green, blue} <= BORDER_RGB;
        end
    end

endmodule

// File: tb/tb_gfx_bitmap_display.sv
// Directed bench for gfx_bitmap_display using a reduced raster of 24 x 13 clk.
// Instance A uses BPP 1 with no scaling: it covers the window, the border,
// the syncs, fb_base latching, mid-frame reset and the palette.
// Instance B uses BPP 2 with 2x2 scaling and a window clipped on the right.
// The cycle index cyc counts negedges from the frame_start cycle.
// The pixel seen at cyc k comes from counter value (k-3): x=(k-3)%24, y=(k-3)/24.
module tb_gfx_bitmap_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  fb_base_a, fb_base_b, addr_a, addr_b, data_a, data_b;
    logic        pal_we_a, pal_we_b;
    logic [3:0]  pal_addr_a, pal_addr_b;
    logic [23:0] pal_data_a, pal_data_b;
    logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        hsync_a, vsync_a, de_a, fs_a, hsync_b, vsync_b, de_b, fs_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef GFX_PALETTE_EN
    localparam logic [23:0] PIX1_A = 24'hFF0000;
`else
    localparam logic [23:0] PIX1_A = 24'hFFFFFF;
`endif

    gfx_bitmap_display #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .FB_WIDTH(8), .FB_HEIGHT(4), .BPP(1),
        .SCALE_X(1), .SCALE_Y(1), .ADDR_W(8), .BORDER_RGB(24'h123456)
    ) dut_a (
        .clk_pixel(clk), .reset(reset), .fb_base(fb_base_a),
        .dispAddr(addr_a), .dispData(data_a),
        .pal_we(pal_we_a), .pal_addr(pal_addr_a), .pal_data(pal_data_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(fs_a)
    );

    gfx_bitmap_display #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .FB_WIDTH(12), .FB_HEIGHT(2), .BPP(2),
        .SCALE_X(2), .SCALE_Y(2), .ADDR_W(8), .BORDER_RGB(24'h0000FF)
    ) dut_b (
        .clk_pixel(clk), .reset(reset), .fb_base(fb_base_b),
        .dispAddr(addr_b), .dispData(data_b),
        .pal_we(pal_we_b), .pal_addr(pal_addr_b), .pal_data(pal_data_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(fs_b)
    );

    // Synchronous RAMs: data valid one clk after the address.
    always @(posedge clk) begin
        data_a <= mem_a[addr_a];
        data_b <= mem_b[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        fb_base_a  = 8'h00;
        fb_base_b  = 8'h00;
        pal_we_a   = 1'b0;
        pal_we_b   = 1'b0;
        pal_addr_a = 4'h0;
        pal_addr_b = 4'h0;
        pal_data_a = 24'h0;
        pal_data_b = 24'h0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        mem_a[0]    = 8'h01;
        mem_a[1]    = 8'h80;
        mem_a[3]    = 8'h00;
        mem_a[8'h40] = 8'h02;
        mem_a[8'h43] = 8'hFF;
        mem_b[0]    = 8'b11100100;
        mem_b[1]    = 8'h03;
        mem_b[3]    = 8'h02;

        repeat (3) @(negedge clk);
        chk("rst_de", de_a, 0);
        chk("rst_rgb", {red_a, green_a, blue_a}, 0);
        chk("rst_hsync", hsync_a, 0);
        chk("rst_vsync", vsync_a, 0);
        chk("rst_fs", fs_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_de_b", de_b, 0);

        reset = 1'b0;
        @(negedge clk);
        cyc = 0;
        chk("fs_first", fs_a, 1);
        pal_we_a   = 1'b1;
        pal_addr_a = 4'h1;
        pal_data_a = 24'hFF0000;
        goto(1);
        pal_we_a = 1'b0;
        chk("fs_drop", fs_a, 0);
        chk("addr_first", addr_a, 0);
        chk("de_flush1", de_a, 0);
        goto(2);
        chk("de_flush2", de_a, 0);
        goto(3);
        chk("a_de_x0", de_a, 1);
        chk("a_rgb_x0", {red_a, green_a, blue_a}, PIX1_A);
        chk("b_de_x0", de_b, 1);
        chk("b_rgb_x0", {red_b, green_b, blue_b}, 24'h000000);
        goto(4);
        chk("a_rgb_x1", {red_a, green_a, blue_a}, 24'h000000);
        chk("b_rgb_x1", {red_b, green_b, blue_b}, 24'h000000);
        goto(5);
        chk("b_rgb_x2", {red_b, green_b, blue_b}, 24'h555555);
        goto(7);
        chk("b_rgb_x4", {red_b, green_b, blue_b}, 24'hAAAAAA);
        goto(9);
        chk("b_rgb_x6", {red_b, green_b, blue_b}, 24'hFFFFFF);
        goto(10);
        chk("a_rgb_x7", {red_a, green_a, blue_a}, 24'h000000);
        goto(11);
        chk("a_border_x8", {red_a, green_a, blue_a}, 24'h123456);
        chk("b_rgb_x8", {red_b, green_b, blue_b}, 24'hFFFFFF);
        goto(13);
        chk("b_rgb_x10", {red_b, green_b, blue_b}, 24'h000000);
        goto(18);
        chk("a_border_x15", {red_a, green_a, blue_a}, 24'h123456);
        chk("b_clip_x15", {red_b, green_b, blue_b}, 24'h000000);
        goto(19);
        chk("a_de_x16", de_a, 0);
        chk("a_rgb_x16", {red_a, green_a, blue_a}, 24'h000000);
        goto(20);
        chk("hs_before", hsync_a, 0);
        goto(21);
        chk("hs_start", hsync_a, 1);
        goto(23);
        chk("hs_last", hsync_a, 1);
        goto(24);
        chk("hs_end", hsync_a, 0);
        goto(34);
        chk("a_rgb_row1_x7", {red_a, green_a, blue_a}, PIX1_A);
        goto(45);
        chk("hs_line1", hsync_a, 1);
        goto(49);
        fb_base_a = 8'h40;
        chk("b_addr_row2", addr_b, 8'h03);
        goto(51);
        chk("b_rgb_row2", {red_b, green_b, blue_b}, 24'hAAAAAA);
        goto(73);
        chk("a_addr_row3_oldbase", addr_a, 8'h03);
        goto(75);
        chk("a_rgb_row3_oldbase", {red_a, green_a, blue_a}, 24'h000000);
        goto(99);
        chk("a_border_row4", {red_a, green_a, blue_a}, 24'h123456);
        chk("b_border_row4", {red_b, green_b, blue_b}, 24'h0000FF);
        goto(195);
        chk("a_de_row8", de_a, 0);
        goto(218);
        chk("vs_before", vsync_a, 0);
        goto(219);
        chk("vs_start", vsync_a, 1);
        goto(266);
        chk("vs_last", vsync_a, 1);
        goto(267);
        chk("vs_end", vsync_a, 0);
        goto(311);
        chk("fs_pre_frame2", fs_a, 0);
        goto(312);
        chk("fs_frame2", fs_a, 1);
        goto(313);
        chk("addr_frame2_newbase", addr_a, 8'h40);
        goto(315);
        chk("a_rgb_f2_x0", {red_a, green_a, blue_a}, 24'h000000);
        goto(316);
        chk("a_rgb_f2_x1", {red_a, green_a, blue_a}, PIX1_A);

        goto(462);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_de", de_a, 0);
        chk("mid_rst_rgb", {red_a, green_a, blue_a}, 0);
        chk("mid_rst_hsync", hsync_a, 0);
        chk("mid_rst_fs", fs_a, 0);
        chk("mid_rst_addr", addr_a, 0);
        reset = 1'b0;
        @(negedge clk);
        cyc = 0;
        chk("mid_fs_restart", fs_a, 1);
        goto(2);
        chk("mid_de_flush", de_a, 0);
        goto(3);
        chk("mid_de_x0", de_a, 1);
        chk("mid_rgb_x0", {red_a, green_a, blue_a}, 24'h000000);
        goto(4);
        chk("mid_rgb_x1_palreset", {red_a, green_a, blue_a}, 24'hFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
